// File: rtl/seq_posi_arbiter.sv
// seq_posi_arbiter: arbitrates NREQ requesters onto one fixed-latency position-detect engine.
// Define SEQ_ARB_FIXED_PRIO_EN for lowest-index-wins priority; round-robin otherwise.
module seq_posi_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ENG_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_seq,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          eng_seq,
  input  logic [5:0]           eng_posi,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [5:0]           rsp_posi
);

  localparam int SW = IDW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nx;
  logic [IDW-1:0]  search_start;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [NREQ-1:0] grant_oh;
  logic [31:0]     grant_word;
  logic            accept;
  logic            capture;

  // First set bit of vld searched upward from start, wrapping modulo NREQ; returns {found, idx}.
  function automatic logic [IDW:0] pick_first(input logic [NREQ-1:0] vld,
                                              input logic [IDW-1:0]  start);
    logic           found;
    logic [IDW-1:0] idx;
    logic [SW-1:0]  pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, start} + SW'(k);
      if (pos >= SW'(NREQ)) begin
        pos = pos - SW'(NREQ);
      end else begin
        pos = pos;
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!found && vld[j] && (pos == SW'(j))) begin
          found = 1'b1;
          idx   = IDW'(j);
        end else begin
          found = found;
        end
      end
    end
    return {found, idx};
  endfunction

  // Grant selection: winner index, its one-hot and its request word.
  always_comb begin
    {grant_any, grant_idx} = pick_first(req_valid, search_start);
    grant_oh   = '0;
    grant_word = 32'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_idx == IDW'(j)) begin
        grant_oh[j] = 1'b1;
        grant_word  = req_seq[j*32 +: 32];
      end else begin
        grant_oh[j] = 1'b0;
      end
    end
  end

`ifdef SEQ_ARB_FIXED_PRIO_EN
  assign search_start = '0;
`else
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_next;

  // Pointer advance past the winner, wrapping at NREQ.
  always_comb begin
    if (grant_idx == IDW'(NREQ - 1)) begin
      grant_next = '0;
    end else begin
      grant_next = grant_idx + IDW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= grant_next;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

  assign search_start = rr_ptr;
`endif

  // Next-state, latency counter and handshake decode.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          accept    = 1'b1;
          // ready is forced low while reset is asserted
          req_ready = rst_n ? grant_oh : '0;
          cnt_nx    = 4'(ENG_LAT);
          state_nx  = BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          capture  = 1'b1;
          state_nx = RESP;
        end else begin
          state_nx = BUSY;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = RESP;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      eng_seq   <= 32'd0;
      rsp_id    <= '0;
      rsp_posi  <= 6'd0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        eng_seq <= grant_word;
        rsp_id  <= grant_idx;
      end else begin
        eng_seq <= eng_seq;
        rsp_id  <= rsp_id;
      end
      if (capture) begin
        rsp_posi  <= eng_posi;
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_posi  <= rsp_posi;
        rsp_valid <= 1'b0;
      end else begin
        rsp_posi  <= rsp_posi;
        rsp_valid <= rsp_valid;
      end
    end
  end

endmodule

// File: tb/tb_seq_posi_arbiter.sv
// Directed bench for seq_posi_arbiter: a 4-requester ENG_LAT=2 instance with an engine model
// and a 2-requester ENG_LAT=1 instance whose engine result is driven cycle by cycle.
module tb_seq_posi_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;

  logic [3:0]   req_valid;
  logic [127:0] req_seq;
  logic [3:0]   req_ready;
  logic [31:0]  eng_seq;
  logic [5:0]   eng_posi = 6'd0;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [5:0]   rsp_posi;

  logic [1:0]   b_req_valid;
  logic [63:0]  b_req_seq;
  logic [1:0]   b_req_ready;
  logic [31:0]  b_eng_seq;
  logic [5:0]   b_eng_posi;
  logic         b_rsp_valid;
  logic         b_rsp_ready;
  logic [0:0]   b_rsp_id;
  logic [5:0]   b_rsp_posi;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_posi_arbiter #(.NREQ(4), .IDW(2), .ENG_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_seq(req_seq), .req_ready(req_ready),
    .eng_seq(eng_seq), .eng_posi(eng_posi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_posi(rsp_posi)
  );

  seq_posi_arbiter #(.NREQ(2), .IDW(1), .ENG_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_seq(b_req_seq), .req_ready(b_req_ready),
    .eng_seq(b_eng_seq), .eng_posi(b_eng_posi),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_posi(b_rsp_posi)
  );

  // Engine model: trailing-zero count of eng_seq, one register stage.
  function automatic logic [5:0] ctz(input logic [31:0] w);
    logic [5:0] r;
    r = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (w[i]) r = 6'(i);
    end
    return r;
  endfunction

  always @(posedge clk) eng_posi <= ctz(eng_seq);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  int grant_exp [5];
  int g;
  int after_wrap;
  int after_stall;

  initial begin
`ifdef SEQ_ARB_FIXED_PRIO_EN
    grant_exp   = '{0, 0, 0, 0, 0};
    after_wrap  = 0;
    after_stall = 0;
`else
    grant_exp   = '{0, 1, 2, 3, 0};
    after_wrap  = 2;
    after_stall = 2;
`endif
    rst_n       = 1'b0;
    req_valid   = 4'hf;
    req_seq     = {32'h0000_0080, 32'h0000_0040, 32'h0000_0020, 32'h0000_0100};
    rsp_ready   = 1'b1;
    b_req_valid = 2'b00;
    b_req_seq   = {32'h0000_0300, 32'h0000_0001};
    b_eng_posi  = 6'd0;
    b_rsp_ready = 1'b1;

    // reset state, with requests present during reset
    cyc(); cyc(); #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_eng_seq",   eng_seq,        32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id",    32'(rsp_id),    32'h0);
    chk("rst_rsp_posi",  32'(rsp_posi),  32'h0);
    chk("rst_b_ready",   32'(b_req_ready), 32'h0);
    cyc();
    rst_n     = 1'b1;
    req_valid = 4'h0;

    // single request from requester 0
    cyc();
    req_valid = 4'b0001;
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 4'b0000;
    #1 chk("single_eng_seq", eng_seq, 32'h0000_0100);
    chk("single_busy_ready", 32'(req_ready), 32'h0);
    cyc(); #1 chk("single_t2_valid", 32'(rsp_valid), 32'h0);
    cyc(); #1 chk("single_t3_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_id",   32'(rsp_id),   32'h0);
    chk("single_rsp_posi", 32'(rsp_posi), 32'd8);
    cyc(); #1 chk("single_t4_valid", 32'(rsp_valid), 32'h0);

    // mid-operation reset aborts requester 2
    cyc();
    req_valid = 4'b0100;
    #1 chk("abort_ready", 32'(req_ready), 32'h4);
    cyc();
    req_valid = 4'b0010;
    #1 chk("abort_eng_seq", eng_seq, 32'h0000_0040);
    chk("abort_rsp_id", 32'(rsp_id), 32'h2);
    #2 rst_n = 1'b0;
    #1 chk("abort_eng_seq_rst", eng_seq, 32'h0);
    chk("abort_rsp_id_rst",  32'(rsp_id),    32'h0);
    chk("abort_valid_rst",   32'(rsp_valid), 32'h0);
    chk("abort_ready_rst",   32'(req_ready), 32'h0);
    cyc(); cyc();
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1 chk("abort_no_rsp", 32'(rsp_valid), 32'h0);
    end

    // all four requesters held valid
    req_seq[31:0] = 32'h0000_0010;
    cyc();
    req_valid = 4'hf;
    for (int k = 0; k < 5; k++) begin
      g = grant_exp[k];
      #1 chk("all_grant", 32'(req_ready), 32'h1 << g);
      cyc(); #1 chk("all_busy1", 32'(req_ready), 32'h0);
      cyc(); #1 chk("all_busy2", 32'(req_ready), 32'h0);
      cyc(); #1 chk("all_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("all_rsp_id",   32'(rsp_id),   32'(g));
      chk("all_rsp_posi", 32'(rsp_posi), 32'(4 + g));
      chk("all_resp_ready", 32'(req_ready), 32'h0);
      if (k == 4) req_valid = 4'b0100;
      cyc();
    end

    // wrap-around: serve 2, then only requester 1 pending
    #1 chk("wrap_grant2", 32'(req_ready), 32'h4);
    cyc();
    req_valid = 4'b0010;
    cyc(); cyc();
    #1 chk("wrap_rsp_id2", 32'(rsp_id), 32'h2);
    chk("wrap_rsp_posi2", 32'(rsp_posi), 32'd6);
    rsp_ready = 1'b1;
    cyc(); #1 chk("wrap_grant1", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 4'hf;
    rsp_ready = 1'b0;
    cyc(); cyc();

    // backpressure: 10 stalled cycles in RESP
    for (int i = 0; i < 10; i++) begin
      #1 chk("stall_valid", 32'(rsp_valid), 32'h1);
      chk("stall_id",    32'(rsp_id),    32'h1);
      chk("stall_posi",  32'(rsp_posi),  32'd5);
      chk("stall_ready", 32'(req_ready), 32'h0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("stall_release_valid", 32'(rsp_valid), 32'h1);
    cyc();
    #1 chk("post_stall_grant", 32'(req_ready), 32'h1 << after_wrap);
    chk("post_stall_valid", 32'(rsp_valid), 32'h0);
    cyc();
    req_valid = 4'h0;
    cyc(); cyc();
    #1 chk("post_stall_rsp_id", 32'(rsp_id), 32'(after_stall));
    chk("post_stall_posi", 32'(rsp_posi), 32'(4 + after_stall));

    // ENG_LAT=1 instance: sample point is the cycle after accept
    cyc();
    b_req_valid = 2'b10;
    b_eng_posi  = 6'd3;
    #1 chk("lat1_ready", 32'(b_req_ready), 32'h2);
    cyc();
    b_req_valid = 2'b00;
    b_eng_posi  = 6'd17;
    #1 chk("lat1_eng_seq", b_eng_seq, 32'h0000_0300);
    chk("lat1_t1_valid", 32'(b_rsp_valid), 32'h0);
    cyc();
    b_eng_posi = 6'd9;
    #1 chk("lat1_t2_valid", 32'(b_rsp_valid), 32'h1);
    chk("lat1_rsp_id",   32'(b_rsp_id),   32'h1);
    chk("lat1_rsp_posi", 32'(b_rsp_posi), 32'd17);
    cyc(); #1 chk("lat1_t3_valid", 32'(b_rsp_valid), 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
